hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage MIPS core.
- Drives enable/flush for the four inter-stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Cleans the un-reset buffers after reset, stalls on load-use and RAW hazards, freezes the pipe while data memory is not ready, and squashes wrong-path instructions on taken branches.

---
 rtl/hazard_ctrl_if.sv | 35 +++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Port bundle between the pipeline datapath and hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_ID, rt_ID;
  logic             usesRs_ID, usesRt_ID;
  logic [4:0]       rs_EX, rt_EX;
  logic [4:0]       rd_EX, rd_MEM, rd_WB;
  logic             RegWrite_EX, RegWrite_MEM, RegWrite_WB;
  logic             MemRead_EX, MemReq_MEM, mem_ready, branchTaken_EX;
  logic             pc_en;
  logic             en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic             flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
  logic [1:0]       fwdA, fwdB;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_ID, rt_ID, usesRs_ID, usesRt_ID, rs_EX, rt_EX,
           rd_EX, rd_MEM, rd_WB, RegWrite_EX, RegWrite_MEM, RegWrite_WB,
           MemRead_EX, MemReq_MEM, mem_ready, branchTaken_EX,
    input  pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
           fwdA, fwdB, mem_err, stall_cnt
  );

  modport slave (
    input  rs_ID, rt_ID, usesRs_ID, usesRt_ID, rs_EX, rt_EX,
           rd_EX, rd_MEM, rd_WB, RegWrite_EX, RegWrite_MEM, RegWrite_WB,
           MemRead_EX, MemReq_MEM, mem_ready, branchTaken_EX,
    output pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
           flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
           fwdA, fwdB, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: init flush, hazard stalls,
// memory-wait freeze, branch squash. Define HAZARD_CTRL_FWD_EN for forwarding.
module hazard_ctrl #(
  parameter int INIT_CYC    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic          clk_HC,
  input logic          rst_HC,
  hazard_ctrl_if.slave hc
);
  typedef enum logic [1:0] {INIT, RUN, MEMWAIT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       init_cnt, init_nxt;
  logic [7:0]       wait_cnt, wait_nxt;
  logic             mem_err, err_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_inc, run_sel;
  logic             match_ex, match_mem, hazard;

  always_comb begin
    match_ex  = hc.RegWrite_EX && (hc.rd_EX != '0) &&
                ((hc.usesRs_ID && hc.rs_ID == hc.rd_EX) ||
                 (hc.usesRt_ID && hc.rt_ID == hc.rd_EX));
    match_mem = hc.RegWrite_MEM && (hc.rd_MEM != '0) &&
                ((hc.usesRs_ID && hc.rs_ID == hc.rd_MEM) ||
                 (hc.usesRt_ID && hc.rt_ID == hc.rd_MEM));
`ifdef HAZARD_CTRL_FWD_EN
    hazard = match_ex && hc.MemRead_EX;
    if (hc.RegWrite_MEM && hc.rd_MEM != '0 && hc.rd_MEM == hc.rs_EX)   hc.fwdA = 2'b10;
    else if (hc.RegWrite_WB && hc.rd_WB != '0 && hc.rd_WB == hc.rs_EX) hc.fwdA = 2'b01;
    else                                                               hc.fwdA = 2'b00;
    if (hc.RegWrite_MEM && hc.rd_MEM != '0 && hc.rd_MEM == hc.rt_EX)   hc.fwdB = 2'b10;
    else if (hc.RegWrite_WB && hc.rd_WB != '0 && hc.rd_WB == hc.rt_EX) hc.fwdB = 2'b01;
    else                                                               hc.fwdB = 2'b00;
    if (rst_HC || state == INIT) begin
      hc.fwdA = 2'b00;
      hc.fwdB = 2'b00;
    end
`else
    hazard  = match_ex || match_mem;
    hc.fwdA = 2'b00;
    hc.fwdB = 2'b00;
`endif
  end

  always_comb begin
    state_nxt      = state;
    init_nxt       = init_cnt;
    wait_nxt       = wait_cnt;
    err_nxt        = mem_err;
    stall_inc      = 1'b0;
    run_sel        = 1'b0;
    hc.pc_en       = 1'b1;
    hc.en_IFID     = 1'b1;
    hc.en_IDEX     = 1'b1;
    hc.en_EXMEM    = 1'b1;
    hc.en_MEMWB    = 1'b1;
    hc.flush_IFID  = 1'b0;
    hc.flush_IDEX  = 1'b0;
    hc.flush_EXMEM = 1'b0;
    hc.flush_MEMWB = 1'b0;

    case (state)
      RUN: begin
        if (hc.MemReq_MEM && !hc.mem_ready) begin
          state_nxt = MEMWAIT;
          wait_nxt  = 8'd1;
        end else begin
          run_sel = 1'b1;
        end
      end
      MEMWAIT: begin
        if (hc.mem_ready) begin
          run_sel   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          err_nxt   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = '0;
        end else begin
          wait_nxt  = wait_cnt + 8'd1;
        end
      end
      default: begin
        init_nxt = init_cnt + 4'd1;
        if (init_cnt == 4'(INIT_CYC - 1)) begin
          state_nxt = RUN;
          init_nxt  = '0;
        end
      end
    endcase

    // Memory freeze covers the entry cycle and every unready wait cycle;
    // a ready cycle falls through to the normal RUN priority instead.
    if (state != INIT && !run_sel) begin
      hc.pc_en       = 1'b0;
      hc.en_IFID     = 1'b0;
      hc.en_IDEX     = 1'b0;
      hc.en_EXMEM    = 1'b0;
      hc.flush_MEMWB = 1'b1;
      stall_inc      = 1'b1;
    end else if (run_sel && hc.branchTaken_EX) begin
      hc.flush_IFID  = 1'b1;
      hc.flush_IDEX  = 1'b1;
    end else if (run_sel && hazard) begin
      hc.pc_en       = 1'b0;
      hc.en_IFID     = 1'b0;
      hc.flush_IDEX  = 1'b1;
      stall_inc      = 1'b1;
    end

    if (rst_HC || state == INIT) begin
      hc.pc_en       = 1'b0;
      hc.en_IFID     = 1'b1;
      hc.en_IDEX     = 1'b1;
      hc.en_EXMEM    = 1'b1;
      hc.en_MEMWB    = 1'b1;
      hc.flush_IFID  = 1'b1;
      hc.flush_IDEX  = 1'b1;
      hc.flush_EXMEM = 1'b1;
      hc.flush_MEMWB = 1'b1;
      stall_inc      = 1'b0;
    end
  end

  always_ff @(posedge clk_HC) begin
    if (rst_HC) begin
      state     <= INIT;
      init_cnt  <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
      wait_cnt <= wait_nxt;
      mem_err  <= err_nxt;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hc.mem_err   = mem_err;
  assign hc.stall_cnt = stall_cnt;
endmodule
